// File: rtl/gain_pkg.sv
// ============================================================================
// Module   : gain_pkg
// Brief    : Shared gain range and type for the gain controller, display
//            decoder and gain multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gain_pkg;

  localparam int GAIN_W   = 4;
  localparam int GAIN_MIN = -8;
  localparam int GAIN_MAX = 5;

  typedef logic signed [GAIN_W-1:0] gain_t;

endpackage : gain_pkg

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Brief    : Synchroniser, debouncer and press detector for one raw button;
//            emits a one-cycle step pulse (plus auto-repeat steps when
//            GAIN_CTRL_AUTOREPEAT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
  import gain_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
`ifdef GAIN_CTRL_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_step
);

  localparam int                c_CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CW-1:0]   c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic            r_stable_q;
  logic [c_CW-1:0] r_cnt;
  logic            w_press;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      // Level must disagree with the debounced state on DEBOUNCE_CYCLES
      // consecutive edges before it is accepted.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_press = r_stable & ~r_stable_q;

`ifdef GAIN_CTRL_AUTOREPEAT_EN
  localparam int c_HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_HW   = $clog2(c_HMAX + 1);

  logic [c_HW-1:0] r_hold;
  logic            r_rep;
  logic [c_HW-1:0] w_target;
  logic            w_repeat;

  // First repeat waits REPEAT_DELAY after the press step, later ones REPEAT_PERIOD.
  assign w_target = r_rep ? c_HW'(REPEAT_PERIOD) : c_HW'(REPEAT_DELAY);
  assign w_repeat = r_stable & (r_hold == w_target);

  always_ff @(posedge clk) begin
    if (reset || !r_stable) begin
      r_hold <= '0;
      r_rep  <= 1'b0;
    end else if (w_repeat) begin
      r_hold <= c_HW'(1);
      r_rep  <= 1'b1;
    end else begin
      r_hold <= r_hold + 1'b1;
    end
  end

  assign o_step = w_press | w_repeat;
`else
  assign o_step = w_press;
`endif

endmodule : btn_debounce

`default_nettype wire

// File: rtl/gain_ctrl.sv
// ============================================================================
// Module   : gain_ctrl
// Brief    : Push-button saturating gain controller (-8..+5). Optional
//            auto-repeat on held buttons via GAIN_CTRL_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gain_ctrl
  import gain_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] gain,
  output logic       gain_changed,
  output logic       at_min,
  output logic       at_max
);

  gain_t r_gain;
  logic  r_changed;
  logic  r_min;
  logic  r_max;
  gain_t w_next;
  logic  w_chg;
  logic  w_up;
  logic  w_down;

  if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
  end

`ifdef GAIN_CTRL_AUTOREPEAT_EN
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_up (.clk(clk), .reset(reset), .i_btn(btn_up), .o_step(w_up));

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_down (.clk(clk), .reset(reset), .i_btn(btn_down), .o_step(w_down));
`else
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_up (.clk(clk), .reset(reset), .i_btn(btn_up), .o_step(w_up));

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_down (.clk(clk), .reset(reset), .i_btn(btn_down), .o_step(w_down));
`endif

  // Simultaneous steps cancel; steps at a rail are dropped.
  always_comb begin
    w_next = r_gain;
    w_chg  = 1'b0;
    if (w_up && !w_down && (r_gain < gain_t'(GAIN_MAX))) begin
      w_next = r_gain + gain_t'(1);
      w_chg  = 1'b1;
    end else if (w_down && !w_up && (r_gain > gain_t'(GAIN_MIN))) begin
      w_next = r_gain - gain_t'(1);
      w_chg  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gain    <= '0;
      r_changed <= 1'b0;
      r_min     <= 1'b0;
      r_max     <= 1'b0;
    end else begin
      r_gain    <= w_next;
      r_changed <= w_chg;
      r_min     <= (w_next == gain_t'(GAIN_MIN));
      r_max     <= (w_next == gain_t'(GAIN_MAX));
    end
  end

  assign gain         = r_gain;
  assign gain_changed = r_changed;
  assign at_min       = r_min;
  assign at_max       = r_max;

endmodule : gain_ctrl

`default_nettype wire
